// File: rtl/axi_burst_master.sv
// axi_burst_master: command-driven AXI4 INCR burst master.
// One burst at a time; write beats stream in from a valid/ready source,
// read beats stream out to a valid/ready sink, and completion status is
// reported with a one-cycle done pulse per command.
`timescale 1ns/1ps

module axi_burst_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [7:0]            cmd_len,
  // write beat source
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  // read beat sink
  output logic [DATA_W-1:0]     rd_data,
  output logic [1:0]            rd_resp,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  // completion
  output logic                  done,
  output logic [1:0]            resp,
  // AXI4 write address
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  // AXI4 write data
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wvalid,
  output logic                  wlast,
  input  logic                  wready,
  // AXI4 write response
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  // AXI4 read address
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  // AXI4 read data
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  input  logic                  rlast,
  output logic                  rready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5
  } state_t;

  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_ERR   = 2'b10;
  localparam logic [1:0]  RESP_ABORT = 2'b11;
  // Stall count at which a handshake that still has not happened is abandoned.
  localparam logic [15:0] TO_LIMIT   = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          beat_q, beat_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic [1:0]          resp_q, resp_d;
  logic [15:0]         stall_q, stall_d;

  // Scratch values of the next-state logic.
  logic                hs;
  logic                stall_expired;
  logic [12:0]         span_end;

  // Register all FSM state, burst bookkeeping and the status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      resp_q  <= RESP_OKAY;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      done_q  <= done_d;
      resp_q  <= resp_d;
      stall_q <= stall_d;
    end
  end

  // Next-state, bookkeeping and bus outputs of the burst FSM.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    beat_d   = beat_q;
    err_d    = err_q;
    done_d   = 1'b0;
    resp_d   = resp_q;
    hs       = 1'b0;

    cmd_ready = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    wr_ready  = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;

    // Address and length stay on the bus for the whole command; the
    // downstream slave keeps sampling ARLEN while the burst runs.
    awaddr  = addr_q;
    awlen   = len_q;
    awsize  = 3'b010;
    awburst = 2'b01;
    araddr  = addr_q;
    arlen   = len_q;
    arsize  = 3'b010;
    arburst = 2'b01;
    wdata   = wr_data;
    wstrb   = wr_strb;
    rd_data = rdata;
    rd_resp = rresp;

    // End of the burst within its 4KB page, in 13 bits so 4096 is exact.
    span_end = {1'b0, cmd_addr[11:2], 2'b00}
             + {1'b0, ({2'b00, cmd_len} + 10'd1), 2'b00};

    stall_expired = (TIMEOUT != 0) && (stall_q == TO_LIMIT);

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d = cmd_addr & ~ADDR_W'(3);
          len_d  = cmd_len;
          beat_d = '0;
          err_d  = 1'b0;
          if (span_end > 13'd4096) begin
            // Page-crossing burst: report and drop without touching the bus.
            done_d = 1'b1;
            resp_d = RESP_ABORT;
          end else begin
            state_d = cmd_write ? S_AW : S_AR;
          end
        end
      end

      S_AW: begin
        awvalid = 1'b1;
        if (awready) begin
          hs      = 1'b1;
          state_d = S_W;
        end
      end

      S_W: begin
        wvalid   = wr_valid;
        wr_ready = wready;
        wlast    = (beat_q == len_q);
        if (wr_valid && wready) begin
          hs     = 1'b1;
          beat_d = beat_q + 8'd1;
          if (beat_q == len_q) begin
            state_d = S_B;
          end
        end
      end

      S_B: begin
        bready = 1'b1;
        if (bvalid) begin
          hs      = 1'b1;
          resp_d  = bresp;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          hs      = 1'b1;
          state_d = S_R;
        end
      end

      S_R: begin
        rready   = rd_ready;
        rd_valid = rvalid;
        rd_last  = rlast;
        if (rvalid && rd_ready) begin
          hs     = 1'b1;
          beat_d = beat_q + 8'd1;
          err_d  = err_q | (rresp != RESP_OKAY);
          if (rlast) begin
            // An early or late RLAST is a length error.
            resp_d  = ((beat_q != len_q) || err_d) ? RESP_ERR : RESP_OKAY;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (beat_q == len_q) begin
            // Slave overran the requested length: stop at our last beat.
            resp_d  = RESP_ERR;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A handshake that has stalled too long abandons the command.
    if ((state_q != S_IDLE) && !hs && stall_expired) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
      resp_d  = RESP_ABORT;
    end

    // Stall counter restarts on every handshake and every state change.
    if ((state_q == S_IDLE) || hs || (state_d != state_q)) begin
      stall_d = '0;
    end else begin
      stall_d = stall_q + 16'd1;
    end
  end

  assign done = done_q;
  assign resp = resp_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// Testbench for axi_burst_master: directed commands against a small
// behavioral 256-word AXI4 slave, with a queue-based scoreboard monitor.
`timescale 1ns/1ps

module tb_axi_burst_master;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              cmd_valid, cmd_ready, cmd_write;
  logic [31:0]       cmd_addr;
  logic [7:0]        cmd_len;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              wr_valid, wr_ready;
  logic [31:0]       rd_data;
  logic [1:0]        rd_resp;
  logic              rd_last, rd_valid, rd_ready;
  logic              done;
  logic [1:0]        resp;
  logic [31:0]       awaddr, araddr;
  logic [7:0]        awlen, arlen;
  logic [2:0]        awsize, arsize;
  logic [1:0]        awburst, arburst;
  logic              awvalid, awready, arvalid, arready;
  logic [31:0]       wdata, rdata;
  logic [3:0]        wstrb;
  logic              wvalid, wlast, wready;
  logic [1:0]        bresp, rresp;
  logic              bvalid, bready, rvalid, rlast, rready;

  axi_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_resp(rd_resp), .rd_last(rd_last), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .done(done), .resp(resp),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready)
  );

  // ---------------- behavioral slave ----------------
  logic [31:0] mem [256];
  logic [7:0]  s_wa, s_ra, s_rcnt, s_rlen;
  logic        s_wph, s_rph, s_bv;
  logic        awready_en;

  assign awready = awready_en && !s_wph && !s_bv;
  assign wready  = s_wph;
  assign bvalid  = s_bv;
  assign bresp   = 2'b00;
  assign arready = !s_rph;
  assign rvalid  = s_rph;
  assign rdata   = mem[s_ra];
  assign rresp   = 2'b00;
  assign rlast   = s_rph && (s_rcnt == s_rlen);

  // Slave channel state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_wa <= '0; s_ra <= '0; s_rcnt <= '0; s_rlen <= '0;
      s_wph <= 1'b0; s_rph <= 1'b0; s_bv <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        s_wa  <= awaddr[9:2];
        s_wph <= 1'b1;
      end
      if (wvalid && wready) begin
        s_wa <= s_wa + 8'd1;
        if (wlast) begin
          s_wph <= 1'b0;
          s_bv  <= 1'b1;
        end
      end
      if (bvalid && bready) s_bv <= 1'b0;
      if (arvalid && arready) begin
        s_ra   <= araddr[9:2];
        s_rlen <= arlen;
        s_rcnt <= '0;
        s_rph  <= 1'b1;
      end
      if (rvalid && rready) begin
        s_ra   <= s_ra + 8'd1;
        s_rcnt <= s_rcnt + 8'd1;
        if (rlast) s_rph <= 1'b0;
      end
    end
  end

  // Slave memory with byte strobes.
  always_ff @(posedge clk) begin
    if (!rst && wvalid && wready) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[s_wa][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          aw_hi   = 0;
  logic [31:0] cur_addr = '0;
  logic [7:0]  cur_len  = '0;
  logic [1:0]  exp_resp_q [$];
  logic [32:0] exp_rd_q   [$];
  logic [36:0] exp_w_q    [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  initial begin : monitor
    logic        prev_done;
    logic [36:0] ew;
    logic [32:0] er;
    logic [1:0]  es;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 1'b0;
      end else begin
        if (done) begin
          check("done_pulse_width", 64'(prev_done), 64'd0);
          if (exp_resp_q.size() == 0) fail_now("unexpected_done");
          else begin
            es = exp_resp_q.pop_front();
            check("resp", 64'(resp), 64'(es));
          end
        end
        prev_done = done;
        if (rd_valid && rd_ready) begin
          if (exp_rd_q.size() == 0) fail_now("unexpected_rd_beat");
          else begin
            er = exp_rd_q.pop_front();
            check("rd_data", 64'(rd_data), 64'(er[31:0]));
            check("rd_last", 64'(rd_last), 64'(er[32]));
          end
        end
        if (wvalid && wready) begin
          if (exp_w_q.size() == 0) fail_now("unexpected_w_beat");
          else begin
            ew = exp_w_q.pop_front();
            check("wdata", 64'(wdata), 64'(ew[31:0]));
            check("wstrb", 64'(wstrb), 64'(ew[35:32]));
            check("wlast", 64'(wlast), 64'(ew[36]));
          end
        end
        if (awvalid) begin
          aw_hi++;
          check("awaddr", 64'(awaddr), 64'(cur_addr));
          check("awlen", 64'(awlen), 64'(cur_len));
        end
        if (arvalid) begin
          check("araddr", 64'(araddr), 64'(cur_addr));
          check("arlen", 64'(arlen), 64'(cur_len));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [7:0] l);
    bit ok;
    cur_addr  = a & 32'hFFFF_FFFC;
    cur_len   = l;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) fail_now("cmd_accept_timeout");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input logic [31:0] base, input int n, input logic [3:0] strb,
                            input int last_idx, input bit gap);
    bit ok;
    for (int i = 0; i < n; i++) begin
      exp_w_q.push_back({(i == last_idx), strb, base + 32'(i)});
      wr_data  = base + 32'(i);
      wr_strb  = strb;
      wr_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (wr_ready) begin ok = 1'b1; break; end
        @(posedge clk); #1;
      end
      if (!ok) fail_now("wr_handshake_timeout");
      @(posedge clk); #1;
      wr_valid = 1'b0;
      if (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic push_rd(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_rd_q.push_back({(i == n - 1), base + 32'(i)});
  endtask

  task automatic recv_slow(input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      rd_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rd_ready = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (rd_valid) begin ok = 1'b1; break; end
        @(posedge clk); #1;
      end
      if (!ok) fail_now("rd_beat_timeout");
      @(posedge clk); #1;
    end
    rd_ready = 1'b1;
  endtask

  task automatic wait_done(input int limit);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("done_timeout");
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int n;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_strb = 4'hF; wr_valid = 1'b0; rd_ready = 1'b1;
    awready_en = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_awvalid", 64'(awvalid), 64'd0);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_wlast", 64'(wlast), 64'd0);
    check("rst_bready", 64'(bready), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_awaddr", 64'(awaddr), 64'd0);
    check("rst_awlen", 64'(awlen), 64'd0);
    check("rst_awsize", 64'(awsize), 64'd2);
    check("rst_awburst", 64'(awburst), 64'd1);
    check("rst_arsize", 64'(arsize), 64'd2);
    check("rst_arburst", 64'(arburst), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_resp", 64'(resp), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 4-beat write then read back.
    exp_resp_q.push_back(2'b00);
    do_cmd(1'b1, 32'h10, 8'd3);
    send_beats(32'hA0, 4, 4'hF, 3, 1'b0);
    wait_done(50);
    exp_resp_q.push_back(2'b00);
    push_rd(32'hA0, 4);
    do_cmd(1'b0, 32'h10, 8'd3);
    wait_done(50);

    // Single-beat strobed write over a known word.
    exp_resp_q.push_back(2'b00);
    do_cmd(1'b1, 32'h40, 8'd0);
    send_beats(32'h1111_1111, 1, 4'hF, 0, 1'b0);
    wait_done(50);
    exp_resp_q.push_back(2'b00);
    do_cmd(1'b1, 32'h40, 8'd0);
    send_beats(32'hDEAD_BEEF, 1, 4'b0101, 0, 1'b0);
    wait_done(50);
    exp_resp_q.push_back(2'b00);
    push_rd(32'h11AD_11EF, 1);
    do_cmd(1'b0, 32'h40, 8'd0);
    wait_done(50);

    // 8-beat write with a gapped source, read back through a slow sink.
    exp_resp_q.push_back(2'b00);
    do_cmd(1'b1, 32'h80, 8'd7);
    send_beats(32'hC0, 8, 4'hF, 7, 1'b1);
    wait_done(50);
    exp_resp_q.push_back(2'b00);
    push_rd(32'hC0, 8);
    do_cmd(1'b0, 32'h80, 8'd7);
    recv_slow(8);
    wait_done(50);

    // 4KB reject, then the largest burst that just fits the page.
    exp_resp_q.push_back(2'b11);
    aw_hi = 0;
    do_cmd(1'b1, 32'hFF8, 8'd3);
    @(negedge clk);
    check("reject_done_next_cycle", 64'(done), 64'd1);
    check("reject_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (3) @(negedge clk);
    check("reject_no_awvalid", 64'(aw_hi), 64'd0);
    @(posedge clk); #1;
    exp_resp_q.push_back(2'b00);
    do_cmd(1'b1, 32'hFF0, 8'd3);
    send_beats(32'hF0, 4, 4'hF, 3, 1'b0);
    wait_done(50);

    // AWREADY stuck low: abort after TIMEOUT stalled cycles.
    exp_resp_q.push_back(2'b11);
    awready_en = 1'b0;
    aw_hi = 0;
    do_cmd(1'b1, 32'h20, 8'd0);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    check("timeout_done_cycle", 64'(n), 64'd17);
    check("timeout_awvalid_cycles", 64'(aw_hi), 64'd16);
    check("timeout_awvalid_dropped", 64'(awvalid), 64'd0);
    check("timeout_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    awready_en = 1'b1;

    // Reset during the third write beat.
    do_cmd(1'b1, 32'h60, 8'd3);
    send_beats(32'hE0, 2, 4'hF, 3, 1'b0);
    wr_data  = 32'hE2;
    wr_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("midrst_wvalid", 64'(wvalid), 64'd0);
    check("midrst_wlast", 64'(wlast), 64'd0);
    check("midrst_awaddr", 64'(awaddr), 64'd0);
    check("midrst_awlen", 64'(awlen), 64'd0);
    check("midrst_bready", 64'(bready), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_resp", 64'(resp), 64'd0);
    wr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_resp_q.push_back(2'b00);
    push_rd(32'hA0, 4);
    do_cmd(1'b0, 32'h10, 8'd3);
    wait_done(50);

    repeat (3) @(posedge clk);
    #1;
    check("leftover_resp", 64'(exp_resp_q.size()), 64'd0);
    check("leftover_rd", 64'(exp_rd_q.size()), 64'd0);
    check("leftover_w", 64'(exp_w_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Command-driven AXI4 burst master that sits directly upstream of the team's 256-word AXI4 slave memory and is the only agent driving its five channels. A simple command port (address, length, direction) starts one INCR burst at a time. Write beats stream in from a valid/ready data source; read beats stream out to a valid/ready sink. Completion and response status are reported per command.

## Interface
- ADDR_W, 32, address width of cmd_addr and AxADDR
- DATA_W, 32, data width; fixed at 32, WSTRB is 4 bits
- TIMEOUT, 1024, cycles a single handshake may stall before abort; 0 disables
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  32  byte start address
- cmd_len  in  8  beats minus one (AxLEN)
- wr_data  in  32  write beat data
- wr_strb  in  4  write beat byte strobes
- wr_valid  in  1  write beat offered
- wr_ready  out  1  write beat consumed
- rd_data  out  32  read beat data
- rd_resp  out  2  read beat RRESP
- rd_last  out  1  last read beat
- rd_valid  out  1  read beat offered
- rd_ready  in  1  sink accepts read beat
- done  out  1  one-cycle pulse at command completion
- resp  out  2  status, valid with done: 00 OKAY, 10 SLVERR/length error, 11 timeout or 4KB reject
- AW*, W*, B*, AR*, R*: full AXI4 master side, matching the slave port list (AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WLAST/WREADY, BRESP/BVALID/BREADY, ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID/ARREADY, RDATA/RRESP/RVALID/RLAST/RREADY)

## Operation
- States: IDLE, AW, W, B, AR, R.
- IDLE: cmd_ready=1. On cmd_valid:
  - Latch addr (bits [1:0] forced to 0), len and direction.
  - 4KB check: if addr[11:0] + (len+1)*4 > 4096 (13-bit arithmetic), reject. Pulse done with resp=11, stay IDLE, no bus activity.
  - Otherwise go to AW (write) or AR (read).
- AxSIZE=3'b010 and AxBURST=2'b01 always. AxADDR and AxLEN are held stable from issue until the command completes, because the slave samples ARLEN throughout the burst.
- AW: AWVALID=1 until the AWVALID&&AWREADY edge, then go to W.
- W:
  - WVALID=wr_valid, WDATA=wr_data, WSTRB=wr_strb, wr_ready=WREADY (combinational pass-through).
  - 8-bit beat counter increments on each WVALID&&WREADY. WLAST=(beat==len).
  - Handshake with WLAST goes to B.
- B: BREADY=1. On BVALID, capture BRESP into resp, pulse done, go to IDLE.
- AR: ARVALID=1 until the handshake, then go to R.
- R:
  - RREADY=rd_ready. rd_valid/rd_data/rd_resp/rd_last mirror RVALID/RDATA/RRESP/RLAST.
  - Counter increments on each RVALID&&RREADY.
  - Any RRESP!=00 sets a sticky error.
  - Beat with RLAST ends the burst. If RLAST arrives at beat!=len, resp=10.
  - If beat==len handshakes without RLAST, resp=10 and the burst ends at that beat.
  - Otherwise resp = sticky error ? 10 : 00. Pulse done, go to IDLE.
- Timeout: a 16-bit stall counter resets on every state change and every handshake, and increments otherwise in AW/W/B/AR/R.
  - At TIMEOUT: drop all VALID/READY, pulse done with resp=11, go to IDLE.
  - Abandoned slave state is the system's concern; the bench must reset both.

## Timing
- Reset values: cmd_ready=1, all AXI VALID/READY=0, WLAST=0, AxADDR=0, AxLEN=0, AxSIZE=3'b010, AxBURST=2'b01, done=0, resp=00, rd_valid=0. The counters and state return to IDLE/0.
- Reset mid-burst returns to IDLE immediately. No done is generated.
- Command acceptance to AWVALID/ARVALID high: 1 cycle.
- AWREADY/ARREADY may rise any number of cycles after VALID; VALID never drops before the handshake.
- W and R data paths add zero cycles of latency.
- done is registered: it rises the cycle after the final B or R handshake. cmd_ready rises in the same cycle, so back-to-back commands are accepted with one idle cycle.
- cmd_len=0 yields a single beat, with WLAST high on the first beat.

## Test plan
- Write 4 beats (len=3) to 0x10 with data 0xA0..0xA3, strb=F, then read 4 beats from 0x10 -> rd_data A0,A1,A2,A3, rd_last only on the 4th beat, two done pulses, both resp=00.
- Single-beat write to 0x40 with 0xDEADBEEF, strb=0101, over prior 0x11111111 -> read-back 0x11AD11EF, WLAST on beat 0.
- Write len=7 with wr_valid toggling every other cycle and rd_ready held low 3 cycles per beat -> no beat lost or duplicated, counters correct, WLAST only on beat 7.
- Command addr=0xFF8, len=3 -> done with resp=11 one cycle after acceptance, AWVALID never asserted. Then addr=0xFF0, len=3 -> accepted.
- AWREADY tied low, TIMEOUT=16 -> done with resp=11 after 16 stalled cycles, AWVALID deasserted, returns to IDLE.
- Assert rst during the beat-2 W phase -> all outputs at reset values asynchronously, cmd_ready=1. A following read command completes with resp=00.
